rvm_session_ctrl: RTL and testbench

- Session and credit controller for the reverse vending machine (RVM), sitting downstream of the item-classifier FSM.
- Consumes the classifier's single-cycle bottle, can and reject pulses; tracks per-bin fill levels and gates intake when a bin is full.
- Accumulates user credit for the current session and performs a req/ack voucher handshake when the session ends.
- Drives intake_en back to the classifier/sensor front end; that is how this block sequences the classifier.

---
 rtl/rvm_session_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_rvm_session_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvm_session_ctrl.sv
// Reverse vending machine session/credit controller: counts classifier pulses,
// tracks bin fill, accumulates credit and runs the voucher req/ack handshake.
module rvm_session_ctrl #(
    parameter int unsigned BOTTLE_VALUE = 10,
    parameter int unsigned CAN_VALUE    = 5,
    parameter int unsigned CREDIT_W     = 12,
    parameter int unsigned BIN_W        = 8,
    parameter int unsigned BOTTLE_CAP   = 50,
    parameter int unsigned CAN_CAP      = 80,
    parameter int unsigned IDLE_TO      = 1000,
    parameter int unsigned ACK_TO       = 200
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bottle_pulse,
    input  logic                can_pulse,
    input  logic                reject_pulse,
    input  logic                finish_btn,
    input  logic                service_clr,
    input  logic                voucher_ack,
    output logic                intake_en,
    output logic                voucher_req,
    output logic [CREDIT_W-1:0] voucher_amount,
    output logic [CREDIT_W-1:0] credit,
    output logic                bottle_full,
    output logic                can_full,
    output logic                session_active,
    output logic [3:0]          reject_cnt,
    output logic                fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_PAYOUT,
        S_FAULT
    } state_t;

    localparam int unsigned IT_W = $clog2(IDLE_TO + 1);
    localparam int unsigned AT_W = $clog2(ACK_TO + 1);

    localparam logic [IT_W-1:0]     IDLE_LAST  = IT_W'(IDLE_TO - 1);
    localparam logic [AT_W-1:0]     ACK_LAST   = AT_W'(ACK_TO - 1);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
    localparam logic [BIN_W-1:0]    BIN_MAX    = '1;
    localparam logic [CREDIT_W:0]   BOTTLE_INC = (CREDIT_W + 1)'(BOTTLE_VALUE);
    localparam logic [CREDIT_W:0]   CAN_INC    = (CREDIT_W + 1)'(CAN_VALUE);
    localparam logic [BIN_W-1:0]    BOTTLE_LIM = BIN_W'(BOTTLE_CAP);
    localparam logic [BIN_W-1:0]    CAN_LIM    = BIN_W'(CAN_CAP);

    state_t              state_q, state_d;
    logic                fin_prev_q;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] amount_q, amount_d;
    logic                req_q, req_d;
    logic [BIN_W-1:0]    bottle_bin_q, bottle_bin_d;
    logic [BIN_W-1:0]    can_bin_q, can_bin_d;
    logic                bottle_full_q, bottle_full_d;
    logic                can_full_q, can_full_d;
    logic                intake_q, intake_d;
    logic                active_q, active_d;
    logic                fault_q, fault_d;
    logic [3:0]          rej_q, rej_d;
    logic [IT_W-1:0]     idle_tmr_q, idle_tmr_d;
    logic [AT_W-1:0]     ack_tmr_q, ack_tmr_d;

    logic                fin_edge;
    logic                any_pulse;
    logic [CREDIT_W:0]   item_val;
    logic [CREDIT_W:0]   credit_sum;
    logic [CREDIT_W-1:0] credit_add;
    logic [3:0]          rej_inc;

    always_comb begin
        fin_edge   = finish_btn & ~fin_prev_q;
        any_pulse  = bottle_pulse | can_pulse | reject_pulse;
        item_val   = (bottle_pulse ? BOTTLE_INC : '0) + (can_pulse ? CAN_INC : '0);
        credit_sum = {1'b0, credit_q} + item_val;
        credit_add = credit_sum > {1'b0, CREDIT_MAX} ? CREDIT_MAX : credit_sum[CREDIT_W-1:0];
        rej_inc    = (reject_pulse && rej_q != 4'hF) ? rej_q + 4'd1 : rej_q;

        state_d    = state_q;
        credit_d   = credit_q;
        amount_d   = amount_q;
        req_d      = req_q;
        rej_d      = rej_q;
        idle_tmr_d = idle_tmr_q;
        ack_tmr_d  = ack_tmr_q;

        // Bins count items in flight in every state; service_clr overrides a same-cycle pulse
        bottle_bin_d = (bottle_pulse && bottle_bin_q != BIN_MAX) ? bottle_bin_q + 1'b1 : bottle_bin_q;
        can_bin_d    = (can_pulse && can_bin_q != BIN_MAX) ? can_bin_q + 1'b1 : can_bin_q;
        if (service_clr) begin
            bottle_bin_d = '0;
            can_bin_d    = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (any_pulse) begin
                    state_d    = S_ACTIVE;
                    credit_d   = credit_add;
                    rej_d      = rej_inc;
                    idle_tmr_d = '0;
                end
            end
            S_ACTIVE: begin
                credit_d   = credit_add;
                rej_d      = rej_inc;
                idle_tmr_d = any_pulse ? '0 : idle_tmr_q + 1'b1;
                // Same-cycle items are already folded into credit_add before the payout decision
                if (fin_edge || idle_tmr_q == IDLE_LAST) begin
                    idle_tmr_d = '0;
                    if (credit_add != '0) begin
                        state_d   = S_PAYOUT;
                        amount_d  = credit_add;
                        req_d     = 1'b1;
                        ack_tmr_d = '0;
                    end else begin
                        state_d = S_IDLE;
                        rej_d   = '0;
                    end
                end
            end
            S_PAYOUT: begin
                if (voucher_ack) begin
                    state_d  = S_IDLE;
                    req_d    = 1'b0;
                    credit_d = '0;
                    rej_d    = '0;
                    amount_d = '0;
                end else if (ack_tmr_q == ACK_LAST) begin
                    state_d = S_FAULT;
                    req_d   = 1'b0;
                end else begin
                    ack_tmr_d = ack_tmr_q + 1'b1;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        bottle_full_d = bottle_bin_d >= BOTTLE_LIM;
        can_full_d    = can_bin_d >= CAN_LIM;
        intake_d      = (state_d == S_IDLE || state_d == S_ACTIVE) && !bottle_full_d && !can_full_d;
        active_d      = (state_d == S_ACTIVE);
        fault_d       = (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            fin_prev_q    <= 1'b0;
            credit_q      <= '0;
            amount_q      <= '0;
            req_q         <= 1'b0;
            bottle_bin_q  <= '0;
            can_bin_q     <= '0;
            bottle_full_q <= 1'b0;
            can_full_q    <= 1'b0;
            intake_q      <= 1'b1;
            active_q      <= 1'b0;
            fault_q       <= 1'b0;
            rej_q         <= '0;
            idle_tmr_q    <= '0;
            ack_tmr_q     <= '0;
        end else begin
            state_q       <= state_d;
            fin_prev_q    <= finish_btn;
            credit_q      <= credit_d;
            amount_q      <= amount_d;
            req_q         <= req_d;
            bottle_bin_q  <= bottle_bin_d;
            can_bin_q     <= can_bin_d;
            bottle_full_q <= bottle_full_d;
            can_full_q    <= can_full_d;
            intake_q      <= intake_d;
            active_q      <= active_d;
            fault_q       <= fault_d;
            rej_q         <= rej_d;
            idle_tmr_q    <= idle_tmr_d;
            ack_tmr_q     <= ack_tmr_d;
        end
    end

    assign intake_en      = intake_q;
    assign voucher_req    = req_q;
    assign voucher_amount = amount_q;
    assign credit         = credit_q;
    assign bottle_full    = bottle_full_q;
    assign can_full       = can_full_q;
    assign session_active = active_q;
    assign reject_cnt     = rej_q;
    assign fault          = fault_q;

endmodule

// File: tb/tb_rvm_session_ctrl.sv
// Bench for rvm_session_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a behavioural session model.
module tb_rvm_session_ctrl;

    localparam int unsigned CW         = 12;
    localparam int unsigned BW         = 8;
    localparam int unsigned BOTTLE_CAP = 50;
    localparam int unsigned CAN_CAP    = 80;
    localparam int unsigned TB_IDLE_TO = 24;
    localparam int unsigned TB_ACK_TO  = 10;
    localparam int          CREDIT_MAX = (1 << CW) - 1;
    localparam int          BIN_MAX    = (1 << BW) - 1;

    logic          clk;
    logic          reset;
    logic          bottle_pulse;
    logic          can_pulse;
    logic          reject_pulse;
    logic          finish_btn;
    logic          service_clr;
    logic          voucher_ack;
    logic          intake_en;
    logic          voucher_req;
    logic [CW-1:0] voucher_amount;
    logic [CW-1:0] credit;
    logic          bottle_full;
    logic          can_full;
    logic          session_active;
    logic [3:0]    reject_cnt;
    logic          fault;

    rvm_session_ctrl #(
        .BOTTLE_VALUE(10),
        .CAN_VALUE   (5),
        .CREDIT_W    (CW),
        .BIN_W       (BW),
        .BOTTLE_CAP  (BOTTLE_CAP),
        .CAN_CAP     (CAN_CAP),
        .IDLE_TO     (TB_IDLE_TO),
        .ACK_TO      (TB_ACK_TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bottle_pulse  (bottle_pulse),
        .can_pulse     (can_pulse),
        .reject_pulse  (reject_pulse),
        .finish_btn    (finish_btn),
        .service_clr   (service_clr),
        .voucher_ack   (voucher_ack),
        .intake_en     (intake_en),
        .voucher_req   (voucher_req),
        .voucher_amount(voucher_amount),
        .credit        (credit),
        .bottle_full   (bottle_full),
        .can_full      (can_full),
        .session_active(session_active),
        .reject_cnt    (reject_cnt),
        .fault         (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp;
    int n_bad;

    // Behavioural view of the machine: a session is open, a voucher is
    // outstanding, or the machine is broken; everything else is plain integers.
    bit m_in_session, m_waiting, m_faulted, m_req, m_prev_fin;
    int m_credit, m_amount, m_bottles, m_cans, m_rejects, m_quiet, m_ack_wait;

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_in_session = 0; m_waiting = 0; m_faulted = 0; m_req = 0; m_prev_fin = 0;
        m_credit = 0; m_amount = 0; m_bottles = 0; m_cans = 0;
        m_rejects = 0; m_quiet = 0; m_ack_wait = 0;
    endtask

    task automatic model_step(input bit b, input bit c, input bit r, input bit f,
                              input bit clr, input bit ack, input bit rst);
        bit fin_edge, expired;
        int gain;
        if (rst) begin
            model_reset();
            return;
        end
        fin_edge   = f && !m_prev_fin;
        m_prev_fin = f;
        gain       = (b ? 10 : 0) + (c ? 5 : 0);
        m_bottles  = clr ? 0 : sat(m_bottles + int'(b), BIN_MAX);
        m_cans     = clr ? 0 : sat(m_cans + int'(c), BIN_MAX);
        if (m_faulted) begin
            // credit frozen for service readout
        end else if (m_waiting) begin
            if (ack) begin
                m_waiting = 0; m_req = 0; m_credit = 0; m_rejects = 0; m_amount = 0;
            end else if (m_ack_wait == int'(TB_ACK_TO) - 1) begin
                m_waiting = 0; m_faulted = 1; m_req = 0;
            end else begin
                m_ack_wait++;
            end
        end else if (!m_in_session) begin
            if (b || c || r) begin
                m_in_session = 1;
                m_credit     = sat(m_credit + gain, CREDIT_MAX);
                m_rejects    = sat(m_rejects + int'(r), 15);
                m_quiet      = 0;
            end
        end else begin
            m_credit  = sat(m_credit + gain, CREDIT_MAX);
            m_rejects = sat(m_rejects + int'(r), 15);
            expired   = (m_quiet == int'(TB_IDLE_TO) - 1);
            m_quiet   = (b || c || r) ? 0 : m_quiet + 1;
            if (fin_edge || expired) begin
                m_in_session = 0;
                m_quiet      = 0;
                if (m_credit > 0) begin
                    m_waiting = 1; m_ack_wait = 0; m_amount = m_credit; m_req = 1;
                end else begin
                    m_rejects = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        bit exp_intake;
        exp_intake = !m_faulted && !m_waiting &&
                     (m_bottles < int'(BOTTLE_CAP)) && (m_cans < int'(CAN_CAP));
        check("intake_en",      32'(intake_en),      32'(exp_intake));
        check("voucher_req",    32'(voucher_req),    32'(m_req));
        check("voucher_amount", 32'(voucher_amount), 32'(m_amount));
        check("credit",         32'(credit),         32'(m_credit));
        check("bottle_full",    32'(bottle_full),    32'(m_bottles >= int'(BOTTLE_CAP)));
        check("can_full",       32'(can_full),       32'(m_cans >= int'(CAN_CAP)));
        check("session_active", 32'(session_active), 32'(m_in_session));
        check("reject_cnt",     32'(reject_cnt),     32'(m_rejects));
        check("fault",          32'(fault),          32'(m_faulted));
    endtask

    task automatic cycle(input bit b, input bit c, input bit r, input bit f,
                         input bit clr, input bit ack, input bit rst);
        bottle_pulse = b; can_pulse = c; reject_pulse = r; finish_btn = f;
        service_clr  = clr; voucher_ack = ack; reset = rst;
        model_step(b, c, r, f, clr, ack, rst);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        bit saw_req;
        n_cmp = 0;
        n_bad = 0;
        model_reset();

        // Reset state
        do_reset();
        check("rst_intake", 32'(intake_en), 32'd1);
        check("rst_credit", 32'(credit), 32'd0);

        // 3 bottles + 2 cans, finish, ack
        repeat (3) cycle(1, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        check("tp1_req", 32'(voucher_req), 32'd1);
        check("tp1_amount", 32'(voucher_amount), 32'd40);
        cycle(0, 0, 0, 0, 0, 1, 0);
        check("tp1_credit_clr", 32'(credit), 32'd0);
        check("tp1_intake", 32'(intake_en), 32'd1);
        check("tp1_idle", 32'(session_active), 32'd0);

        // Simultaneous bottle and can from IDLE
        do_reset();
        cycle(1, 1, 0, 0, 0, 0, 0);
        check("tp2_active", 32'(session_active), 32'd1);
        check("tp2_credit", 32'(credit), 32'd15);

        // Can bin to capacity, overrun, service clear
        do_reset();
        repeat (CAN_CAP - 1) cycle(0, 1, 0, 0, 0, 0, 0);
        check("tp3_not_full", 32'(can_full), 32'd0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        check("tp3_full", 32'(can_full), 32'd1);
        check("tp3_intake_off", 32'(intake_en), 32'd0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        check("tp3_overrun_credit", 32'(credit), 32'((CAN_CAP + 1) * 5));
        cycle(0, 0, 0, 0, 1, 0, 0);
        check("tp3_clr_full", 32'(can_full), 32'd0);
        check("tp3_clr_intake", 32'(intake_en), 32'd1);

        // Reject then inactivity timeout
        do_reset();
        cycle(0, 0, 1, 0, 0, 0, 0);
        check("tp4_rej", 32'(reject_cnt), 32'd1);
        saw_req = 0;
        for (int i = 0; i < int'(TB_IDLE_TO); i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            saw_req |= voucher_req;
        end
        check("tp4_idle", 32'(session_active), 32'd0);
        check("tp4_no_voucher", 32'(saw_req), 32'd0);
        check("tp4_rej_clr", 32'(reject_cnt), 32'd0);

        // Ack timeout -> fault, then reset
        do_reset();
        repeat (2) cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        repeat (TB_ACK_TO) cycle(0, 0, 0, 1, 0, 0, 0);
        check("tp5_fault", 32'(fault), 32'd1);
        check("tp5_req", 32'(voucher_req), 32'd0);
        check("tp5_intake", 32'(intake_en), 32'd0);
        check("tp5_credit", 32'(credit), 32'd20);
        do_reset();
        check("tp5_rst_fault", 32'(fault), 32'd0);
        check("tp5_rst_intake", 32'(intake_en), 32'd1);

        // Reset during PAYOUT
        repeat (3) cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        check("tp6_amount", 32'(voucher_amount), 32'd30);
        do_reset();
        check("tp6_req", 32'(voucher_req), 32'd0);
        check("tp6_credit", 32'(credit), 32'd0);

        // Credit and bin saturation
        do_reset();
        repeat (420) cycle(1, 0, 0, 0, 0, 0, 0);
        check("sat_credit", 32'(credit), 32'(CREDIT_MAX));
        check("sat_full", 32'(bottle_full), 32'd1);
        do_reset();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bit b, c, r, f, clr, ack, rst;
            b   = ($urandom_range(0, 5) == 0);
            c   = ($urandom_range(0, 5) == 0);
            r   = ($urandom_range(0, 15) == 0);
            f   = ($urandom_range(0, 11) == 0) ? !finish_btn : finish_btn;
            clr = ($urandom_range(0, 60) == 0);
            ack = ($urandom_range(0, 5) == 0);
            rst = m_faulted ? ($urandom_range(0, 8) == 0) : ($urandom_range(0, 400) == 0);
            cycle(b, c, r, f, clr, ack, rst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
